// File: rtl/sdram_init_monitor.sv
// sdram_init_monitor
// Passive checker for the SDRAM power-up initialisation sequence. It samples
// the command/address bus every rising edge and follows the protocol: power-up
// wait, PRECHARGE ALL, REF_COUNT AUTO REFRESHes, then MODE REGISTER SET. It
// publishes the programmed mode fields and latches the first violation. It
// never drives the bus.
//
// Ports:
//   clk            system clock, rising-edge sampling
//   rst_n          asynchronous active-low reset
//   sdram_cmds     {CSn,RASn,CASn,WEn} as seen on the SDRAM pins
//   sdram_addrs    A[12:0], aligned with sdram_cmds
//   init_done      a legal MRS has completed the sequence
//   mode_reg       raw A[12:0] of the last legal MRS
//   burst_len_code mode_reg[2:0]
//   burst_type     mode_reg[3], 0 = sequential
//   cas_latency    mode_reg[6:4]
//   write_single   mode_reg[9]
//   ref_count      AUTO REFRESHes seen during init, saturating at 15
//   err            sticky error flag
//   err_code       first error: 1 early, 2 order, 3 tRP, 4 tRC, 5 tMRD, 6 mode
module sdram_init_monitor #(
  parameter int CLK_FREQ_MHz = 50,
  parameter int INIT_US      = 200,
  parameter int T_RP_CYC     = 1,
  parameter int T_RC_CYC     = 4,
  parameter int T_MRD_CYC    = 2,
  parameter int REF_COUNT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sdram_cmds,
  input  logic [12:0] sdram_addrs,
  output logic        init_done,
  output logic [12:0] mode_reg,
  output logic [2:0]  burst_len_code,
  output logic        burst_type,
  output logic [2:0]  cas_latency,
  output logic        write_single,
  output logic [3:0]  ref_count,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam int INIT_CYC = INIT_US * CLK_FREQ_MHz;
  localparam int PWR_W    = (INIT_CYC < 2) ? 1 : $clog2(INIT_CYC + 1);

  localparam logic [PWR_W-1:0] INIT_CYC_W  = PWR_W'(INIT_CYC);
  localparam logic [7:0]       T_RP_W      = 8'(T_RP_CYC);
  localparam logic [7:0]       T_RC_W      = 8'(T_RC_CYC);
  localparam logic [7:0]       T_MRD_W     = 8'(T_MRD_CYC);
  localparam logic [3:0]       REF_COUNT_W = 4'(REF_COUNT);

  typedef enum logic [2:0] {
    S_WAIT_PWR, S_WAIT_REF, S_WAIT_MRS, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    K_NOP, K_PRE, K_REF, K_MRS, K_OTHER
  } kind_t;

  state_t           state_q, state_d;
  kind_t            kind, prev_q;
  logic [PWR_W-1:0] pwr_q;
  logic [7:0]       gap_q;
  logic [3:0]       ref_q, ref_inc_val;
  logic [12:0]      mode_q;
  logic             done_q, err_q;
  logic [2:0]       code_q;

  logic [2:0] ord_err, tim_err, mode_err, code_d;
  logic       capture, ref_inc, mode_ok;

  // Command decode; deselect (CSn=1) is folded into NOP.
  always_comb begin
    kind = K_OTHER;
    if (sdram_cmds[3] || sdram_cmds == 4'b0111) kind = K_NOP;
    else if (sdram_cmds == 4'b0010)              kind = K_PRE;
    else if (sdram_cmds == 4'b0001)              kind = K_REF;
    else if (sdram_cmds == 4'b0000)              kind = K_MRS;
  end

  // Legal mode: CL 2 or 3; burst length code 0..3, or full page (7) only
  // with sequential bursts.
  assign mode_ok = (sdram_addrs[6:4] == 3'd2 || sdram_addrs[6:4] == 3'd3) &&
                   (!sdram_addrs[2] || (sdram_addrs[2:0] == 3'd7 && !sdram_addrs[3]));

  assign ref_inc_val = (ref_q == 4'hF) ? 4'hF : ref_q + 4'd1;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    ord_err  = 3'd0;
    tim_err  = 3'd0;
    mode_err = 3'd0;
    code_d   = 3'd0;
    capture  = 1'b0;
    ref_inc  = 1'b0;

    if (kind != K_NOP) begin
      case (state_q)
        S_WAIT_PWR: begin
          if (pwr_q < INIT_CYC_W)                 ord_err = 3'd1;
          else if (kind == K_PRE && sdram_addrs[10]) state_d = S_WAIT_REF;
          else                                    ord_err = 3'd2;
        end
        S_WAIT_REF: begin
          if (kind == K_REF) begin
            ref_inc = 1'b1;
            if (ref_inc_val >= REF_COUNT_W) state_d = S_WAIT_MRS;
          end else begin
            ord_err = 3'd2;
          end
        end
        S_WAIT_MRS: begin
          if (kind == K_MRS) begin
            if (mode_ok) begin
              capture = 1'b1;
              state_d = S_DONE;
            end else begin
              mode_err = 3'd6;
            end
          end else if (kind == K_REF) begin
            ref_inc = 1'b1;
          end else begin
            ord_err = 3'd2;
          end
        end
        S_DONE: begin
          if (kind == K_MRS) begin
            if (mode_ok) capture  = 1'b1;
            else         mode_err = 3'd6;
          end
        end
        default: ;
      endcase

      // The gap counter measures distance from the previous non-NOP command.
      if (state_q != S_ERROR) begin
        case (prev_q)
          K_PRE:   if (gap_q < T_RP_W)  tim_err = 3'd3;
          K_REF:   if (gap_q < T_RC_W)  tim_err = 3'd4;
          K_MRS:   if (gap_q < T_MRD_W) tim_err = 3'd5;
          default: ;
        endcase
      end
    end

    // Lowest code wins when one sample breaks several rules.
    if (ord_err != 3'd0)      code_d = ord_err;
    else if (tim_err != 3'd0) code_d = tim_err;
    else                      code_d = mode_err;

    // An offending sample must not update any published field.
    if (code_d != 3'd0) begin
      state_d = S_ERROR;
      capture = 1'b0;
      ref_inc = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT_PWR;
      prev_q  <= K_NOP;
      pwr_q   <= '0;
      gap_q   <= 8'hFF;
      ref_q   <= 4'd0;
      mode_q  <= 13'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      if (pwr_q != INIT_CYC_W) pwr_q <= pwr_q + PWR_W'(1);
      if (kind != K_NOP) begin
        gap_q  <= 8'd1;
        prev_q <= kind;
      end else if (gap_q != 8'hFF) begin
        gap_q <= gap_q + 8'd1;
      end
      if (ref_inc) ref_q  <= ref_inc_val;
      if (capture) mode_q <= sdram_addrs;
      done_q <= (state_d == S_DONE);
      if (code_d != 3'd0 && !err_q) begin
        err_q  <= 1'b1;
        code_q <= code_d;
      end
    end
  end

  assign init_done      = done_q;
  assign mode_reg       = mode_q;
  assign burst_len_code = mode_q[2:0];
  assign burst_type     = mode_q[3];
  assign cas_latency    = mode_q[6:4];
  assign write_single   = mode_q[9];
  assign ref_count      = ref_q;
  assign err            = err_q;
  assign err_code       = code_q;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// tb_sdram_init_monitor
// Directed bench for sdram_init_monitor at default parameters. Stimulus
// pushes hand-computed expected output snapshots into a scoreboard queue,
// tagged with the cycle after which they must hold; a separate monitor pops
// and compares them on the falling edge.
module tb_sdram_init_monitor;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] MRS  = 4'b0000;
  localparam logic [3:0] ACT  = 4'b0011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sdram_cmds;
  logic [12:0] sdram_addrs;
  logic        init_done;
  logic [12:0] mode_reg;
  logic [2:0]  burst_len_code;
  logic        burst_type;
  logic [2:0]  cas_latency;
  logic        write_single;
  logic [3:0]  ref_count;
  logic        err;
  logic [2:0]  err_code;

  sdram_init_monitor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sdram_cmds     (sdram_cmds),
    .sdram_addrs    (sdram_addrs),
    .init_done      (init_done),
    .mode_reg       (mode_reg),
    .burst_len_code (burst_len_code),
    .burst_type     (burst_type),
    .cas_latency    (cas_latency),
    .write_single   (write_single),
    .ref_count      (ref_count),
    .err            (err),
    .err_code       (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          due;
    logic        done;
    logic [12:0] mr;
    logic [2:0]  bl;
    logic        bt;
    logic [2:0]  cl;
    logic        ws;
    logic [3:0]  rc;
    logic        e;
    logic [2:0]  code;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare(input exp_t e);
    check({e.name, ".init_done"},      16'(init_done),      16'(e.done));
    check({e.name, ".mode_reg"},       16'(mode_reg),       16'(e.mr));
    check({e.name, ".burst_len_code"}, 16'(burst_len_code), 16'(e.bl));
    check({e.name, ".burst_type"},     16'(burst_type),     16'(e.bt));
    check({e.name, ".cas_latency"},    16'(cas_latency),    16'(e.cl));
    check({e.name, ".write_single"},   16'(write_single),   16'(e.ws));
    check({e.name, ".ref_count"},      16'(ref_count),      16'(e.rc));
    check({e.name, ".err"},            16'(err),            16'(e.e));
    check({e.name, ".err_code"},       16'(err_code),       16'(e.code));
  endtask

  // Monitor: outputs are compared on the falling edge, away from sampling.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) compare(sb.pop_front());
  end

  // Queue an expected snapshot that must hold after the most recent edge.
  task automatic expect_now(input string n, input logic d, input logic [12:0] mr,
                            input logic [2:0] bl, input logic bt, input logic [2:0] cl,
                            input logic ws, input logic [3:0] rc, input logic e,
                            input logic [2:0] c);
    exp_t x;
    x.name = n; x.due = cyc; x.done = d; x.mr = mr; x.bl = bl; x.bt = bt;
    x.cl = cl; x.ws = ws; x.rc = rc; x.e = e; x.code = c;
    sb.push_back(x);
  endtask

  task automatic nops(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one command so it is sampled on the next rising edge.
  task automatic cmd(input logic [3:0] c, input logic [12:0] a);
    sdram_cmds  = c;
    sdram_addrs = a;
    @(posedge clk);
    #1;
    sdram_cmds  = NOP;
    sdram_addrs = 13'd0;
  endtask

  // One-cycle reset pulse; outputs are checked while reset is held.
  task automatic restart(input string n);
    nops(2);
    rst_n = 1'b0;
    expect_now(n, 0, 13'h0000, 0, 0, 0, 0, 4'd0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    sdram_cmds  = NOP;
    sdram_addrs = 13'd0;
    restart("reset_state");

    // Command long before the power-up wait expires.
    nops(499);
    cmd(PRE, 13'h1FFF);
    expect_now("early_cmd", 0, 13'h0000, 0, 0, 0, 0, 4'd0, 1, 3'd1);
    nops(3);
    cmd(PRE, 13'h1FFF);
    cmd(AREF, 13'h0000);
    nops(4);
    cmd(AREF, 13'h0000);
    nops(3);
    cmd(MRS, 13'h0032);
    expect_now("early_frozen", 0, 13'h0000, 0, 0, 0, 0, 4'd0, 1, 3'd1);

    // MRS after one refresh, back-to-back: order error outranks tRC.
    restart("rst_order");
    nops(10000);
    cmd(PRE, 13'h0400);
    cmd(AREF, 13'h0000);
    expect_now("order_ref1", 0, 13'h0000, 0, 0, 0, 0, 4'd1, 0, 3'd0);
    cmd(MRS, 13'h0032);
    expect_now("order_mrs", 0, 13'h0000, 0, 0, 0, 0, 4'd1, 1, 3'd2);

    // PRECHARGE without A10 as the first command.
    restart("rst_pre_a10");
    nops(10000);
    cmd(PRE, 13'h1BFF);
    expect_now("pre_not_all", 0, 13'h0000, 0, 0, 0, 0, 4'd0, 1, 3'd2);

    // Second refresh only 3 cycles after the first.
    restart("rst_trc");
    nops(10000);
    cmd(PRE, 13'h1FFF);
    cmd(AREF, 13'h0000);
    nops(2);
    cmd(AREF, 13'h0000);
    expect_now("trc_gap3", 0, 13'h0000, 0, 0, 0, 0, 4'd1, 1, 3'd4);

    // Illegal CAS latency is flagged and not captured.
    restart("rst_mode");
    nops(10000);
    cmd(PRE, 13'h1FFF);
    cmd(AREF, 13'h0000);
    nops(3);
    cmd(AREF, 13'h0000);
    nops(3);
    cmd(MRS, 13'h0012);
    expect_now("mode_cl1", 0, 13'h0000, 0, 0, 0, 0, 4'd2, 1, 3'd6);

    // Reset between the two refreshes, then a full nominal sequence.
    restart("rst_mid_pre");
    nops(10000);
    cmd(PRE, 13'h1FFF);
    expect_now("mid_pre", 0, 13'h0000, 0, 0, 0, 0, 4'd0, 0, 3'd0);
    cmd(AREF, 13'h0000);
    expect_now("mid_ref1", 0, 13'h0000, 0, 0, 0, 0, 4'd1, 0, 3'd0);
    restart("rst_mid_seq");
    nops(10000);
    cmd(PRE, 13'h1FFF);
    cmd(AREF, 13'h0000);
    expect_now("nom_ref1", 0, 13'h0000, 0, 0, 0, 0, 4'd1, 0, 3'd0);
    nops(3);
    cmd(AREF, 13'h0000);
    expect_now("nom_ref2", 0, 13'h0000, 0, 0, 0, 0, 4'd2, 0, 3'd0);
    nops(3);
    cmd(MRS, 13'h0032);
    expect_now("nom_mrs", 1, 13'h0032, 3'd2, 0, 3'd3, 0, 4'd2, 0, 3'd0);
    // Re-program in DONE at exactly the tMRD gap.
    nops(1);
    cmd(MRS, 13'h0223);
    expect_now("done_mrs2", 1, 13'h0223, 3'd3, 0, 3'd2, 1, 4'd2, 0, 3'd0);
    // ACT right after MRS violates tMRD.
    cmd(ACT, 13'h0000);
    expect_now("tmrd_act", 0, 13'h0223, 3'd3, 0, 3'd2, 1, 4'd2, 1, 3'd5);
    nops(3);
    cmd(MRS, 13'h0032);
    expect_now("err_frozen", 0, 13'h0223, 3'd3, 0, 3'd2, 1, 4'd2, 1, 3'd5);

    nops(3);
    check("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_init_monitor.md
Name: sdram_init_monitor

Overview:
Passive receiver for the SDRAM command/address bus driven by the controller's power-up initialisation sequencer. It samples {CSn,RASn,CASn,WEn} and A[12:0] every clock and checks the JEDEC-style init protocol: power-up wait, PRECHARGE ALL, REF_COUNT AUTO REFRESHes, then MODE REGISTER SET. It decodes and publishes the programmed mode-register fields and flags the first protocol or timing violation. It sits in parallel with the SDRAM pins, in simulation benches and as an optional on-chip checker. It never drives the bus.

Parameters:
CLK_FREQ_MHz, 50, clock frequency used to size the power-up wait
INIT_US, 200, minimum power-up wait in microseconds; INIT_CYC = INIT_US*CLK_FREQ_MHz (10000 by default)
T_RP_CYC, 1, minimum gap in cycles from PRECHARGE to the next command
T_RC_CYC, 4, minimum gap in cycles from AUTO REFRESH to the next command
T_MRD_CYC, 2, minimum gap in cycles from MRS to any later non-NOP command
REF_COUNT, 2, AUTO REFRESH commands required before MRS

Ports:
clk  in  1  system clock; all sampling on the rising edge
rst_n  in  1  asynchronous, active-low reset
sdram_cmds  in  4  {CSn,RASn,CASn,WEn} as driven to the SDRAM
sdram_addrs  in  13  SDRAM address bus, aligned with sdram_cmds
init_done  out  1  high once a legal MRS has completed the sequence
mode_reg  out  13  raw A[12:0] captured at the last legal MRS
burst_len_code  out  3  mode_reg[2:0]
burst_type  out  1  mode_reg[3]; 0 = sequential
cas_latency  out  3  mode_reg[6:4]
write_single  out  1  mode_reg[9]
ref_count  out  4  AUTO REFRESHes seen during init, saturating at 15
err  out  1  sticky error flag
err_code  out  3  first error: 0 none, 1 early command, 2 order, 3 tRP, 4 tRC, 5 tMRD, 6 illegal mode

Behaviour:
- Reset state: all outputs 0, state WAIT_PWR, power-up counter 0, gap counter saturated.
- Decode:
  - CSn=1 is DESELECT, treated as NOP. NOP is 0111.
  - PRECHARGE is 0010. It counts as "all banks" only when A10=1.
  - AUTO REFRESH is 0001. MRS is 0000.
  - Any other code with CSn=0 is an "other" command (ACT/READ/WRITE/BST).
- Power-up counter: increments every cycle after reset release and saturates at INIT_CYC.
- Gap counter (8 bits, saturating at 255):
  - Set to 1 on the edge after any non-NOP command is sampled, then increments each cycle.
  - Gap of back-to-back commands = 1.
  - On each sampled non-NOP command, the gap is checked against the rule of the previous command.
- State machine, evaluated only on non-NOP samples:
  - WAIT_PWR: if the power-up counter is below INIT_CYC, any command -> err 1. Otherwise PRECHARGE ALL -> WAIT_REF. Anything else -> err 2.
  - WAIT_REF: AUTO REFRESH -> ref_count+1. When the count reaches REF_COUNT -> WAIT_MRS. Any other command -> err 2.
  - WAIT_MRS: MRS -> check mode, then DONE. AUTO REFRESH -> ref_count+1, stay. Any other command -> err 2.
  - DONE: another MRS re-checks the mode and updates the mode fields. All other commands are accepted without order checks, but tMRD is still enforced.
  - ERROR: terminal until reset. Bus is ignored; all outputs are frozen except err/err_code.
- Timing checks:
  - Command following PRECHARGE with gap < T_RP_CYC -> err 3.
  - Command following AUTO REFRESH with gap < T_RC_CYC -> err 4.
  - Command following MRS with gap < T_MRD_CYC -> err 5.
- Mode check:
  - Legal: cas_latency in {2,3}, burst_len_code in {0,1,2,3}, or 7 with burst_type=0.
  - Otherwise -> err 6. An illegal MRS is not captured.
- Error priority: if several errors apply to one sample, the lowest code wins. err and err_code are registered one cycle after the offending sample and stay sticky.
- Output timing:
  - init_done and mode fields update on the edge after the MRS sample, i.e. 1-cycle latency.
  - init_done stays high in DONE and drops to 0 on entering ERROR.
- Reset mid-operation returns everything to the reset state immediately (asynchronous). The power-up wait restarts.

Test Plan:
1. Nominal sequence, all at the default parameters:
   - NOP to cycle 10001, then PRECHARGE (A=0x1FFF), AUTO REFRESH 1 cycle later, AUTO REFRESH 4 cycles later, MRS 4 cycles later with A=0x0032.
   - Required: init_done=1 on the cycle after MRS; mode_reg=0x0032, cas_latency=3, burst_len_code=2, burst_type=0, ref_count=2, err=0.
2. PRECHARGE at cycle 500 -> err=1, err_code=1 one cycle later; init_done stays 0 for the rest of the run.
3. PRECHARGE, one AUTO REFRESH, then MRS -> err_code=2. PRECHARGE with A10=0 as the first command -> err_code=2.
4. Second AUTO REFRESH 3 cycles after the first (T_RC_CYC=4) -> err_code=4. Repeat at gap 4 -> no error.
5. MRS with A=0x0012 (CL=1) -> err_code=6 and mode_reg stays 0. Separately, legal MRS followed by ACT 1 cycle later (T_MRD_CYC=2) -> err_code=5.
6. Assert rst_n low for 1 cycle between the two refreshes -> all outputs 0. A full nominal sequence started 10000+ cycles after release then passes as in scenario 1.
